// File: rtl/tt_sweep.sv
// Exhaustive truth-table sweeper: drives every N-bit vector (binary or Gray order),
// captures the single-bit response of a circuit under test and counts mismatches.
module tt_sweep #(
   parameter int unsigned N    = 3,
   parameter int unsigned HOLD = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               mode,
   input  logic               dut_resp,
   input  logic [(1<<N)-1:0]  exp_table,
   output logic [N-1:0]       stim,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [(1<<N)-1:0]  table_out,
   output logic [N:0]         err_cnt
);

   localparam int unsigned TW = 1 << N;
   localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N:0]    ERR_MAX   = (N+1)'(TW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [N-1:0]  index;
   logic [HW-1:0] hold_cnt;
   logic          mode_q;

   logic          last_c;
   logic          miss_c;
   logic [N-1:0]  index_next_c;

   // Vector presented for a given sweep position.
   function automatic logic [N-1:0] vec_of(input logic [N-1:0] idx, input logic gray);
      return gray ? (idx ^ (idx >> 1)) : idx;
   endfunction

   assign last_c       = (index == {N{1'b1}});
   assign index_next_c = index + N'(1);
   assign miss_c       = (dut_resp != exp_table[stim]);

   // Sweep control; abort takes priority over a capture on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         index     <= '0;
         hold_cnt  <= '0;
         mode_q    <= 1'b0;
         stim      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         table_out <= '0;
         err_cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= RUN;
                  index     <= '0;
                  hold_cnt  <= '0;
                  mode_q    <= mode;
                  stim      <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  aborted   <= 1'b0;
                  table_out <= '0;
                  err_cnt   <= '0;
               end
            end
            RUN: begin
               if (abort) begin
                  state    <= IDLE;
                  index    <= '0;
                  hold_cnt <= '0;
                  stim     <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b0;
                  aborted  <= 1'b1;
               end else if (hold_cnt == HOLD_LAST) begin
                  table_out[stim] <= dut_resp;
                  if (miss_c && (err_cnt != ERR_MAX)) begin
                     err_cnt <= err_cnt + (N+1)'(1);
                  end
                  hold_cnt <= '0;
                  if (last_c) begin
                     state <= DONE;
                     index <= '0;
                     stim  <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     index <= index_next_c;
                     stim  <= vec_of(index_next_c, mode_q);
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state <= IDLE;
               stim  <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
